// File: rtl/ex_madd_seq_pkg.sv
// Shared constants, state encoding and opcode helpers for the MADD-family EX sequencer.
// Pure declarations: no logic, no latency.
// No flow control of its own; consumers use the stall encodings below.
package ex_madd_seq_pkg;

  localparam int MADD_DATA_W = 32;
  localparam int MADD_OP_W   = 8;

  localparam logic [MADD_OP_W-1:0] EXE_MADD_OP  = 8'b1010_0110;
  localparam logic [MADD_OP_W-1:0] EXE_MADDU_OP = 8'b1010_0111;
  localparam logic [MADD_OP_W-1:0] EXE_MSUB_OP  = 8'b1010_1010;
  localparam logic [MADD_OP_W-1:0] EXE_MSUBU_OP = 8'b1010_1011;

  localparam logic STOP       = 1'b1;
  localparam logic NO_STOP    = 1'b0;
  localparam logic RST_ENABLE = 1'b1;

  // Index of the EX-stage hold bit inside the ctrl stall vector.
  localparam int STALL_EX_BIT = 3;

  typedef enum logic {
    MADD_IDLE = 1'b0,
    MADD_ACC  = 1'b1
  } madd_state_e;

  function automatic logic is_madd_op(input logic [MADD_OP_W-1:0] op);
    return (op == EXE_MADD_OP) || (op == EXE_MADDU_OP) ||
           (op == EXE_MSUB_OP) || (op == EXE_MSUBU_OP);
  endfunction

  function automatic logic is_signed_op(input logic [MADD_OP_W-1:0] op);
    return (op == EXE_MADD_OP) || (op == EXE_MSUB_OP);
  endfunction

  function automatic logic is_sub_op(input logic [MADD_OP_W-1:0] op);
    return (op == EXE_MSUB_OP) || (op == EXE_MSUBU_OP);
  endfunction

endpackage

// File: rtl/ex_madd_seq_if.sv
// EX-stage <-> MADD sequencer signal bundle (operands, HI/LO, stall vector, result).
// Wires only; no latency.
// Backpressure carried by stall (in) and stallreq_o (out).
interface ex_madd_seq_if
  import ex_madd_seq_pkg::*;
#(
  parameter int DATA_W = MADD_DATA_W,
  parameter int OP_W   = MADD_OP_W
);

  logic [5:0]          stall;
  logic [OP_W-1:0]     aluop_i;
  logic [DATA_W-1:0]   reg1_i;
  logic [DATA_W-1:0]   reg2_i;
  logic [DATA_W-1:0]   hi_i;
  logic [DATA_W-1:0]   lo_i;
  logic [2*DATA_W-1:0] hilo_o;
  logic                whilo_o;
  logic                stallreq_o;
  logic                busy_o;

  // Sequencer side.
  modport slave (
    input  stall, aluop_i, reg1_i, reg2_i, hi_i, lo_i,
    output hilo_o, whilo_o, stallreq_o, busy_o
  );

  // EX-stage / driver side.
  modport master (
    output stall, aluop_i, reg1_i, reg2_i, hi_i, lo_i,
    input  hilo_o, whilo_o, stallreq_o, busy_o
  );

endinterface

// File: rtl/ex_madd_seq_mul_core.sv
// Combinational DATA_W x DATA_W multiplier, signed (sign-magnitude) or unsigned, 2*DATA_W result.
// Latency: 0 cycles (purely combinational).
// No backpressure; output follows inputs.
module ex_madd_seq_mul_core #(
  parameter int DATA_W = 32
) (
  input  logic                signed_i,
  input  logic [DATA_W-1:0]   a_i,
  input  logic [DATA_W-1:0]   b_i,
  output logic [2*DATA_W-1:0] prod_o
);

  logic                a_neg;
  logic                b_neg;
  logic [DATA_W-1:0]   a_mag;
  logic [DATA_W-1:0]   b_mag;
  logic [2*DATA_W-1:0] umul;

  // Reduce signed operands to magnitudes, multiply unsigned, then restore the sign.
  // The most negative value maps onto its own bit pattern, which is the correct magnitude.
  always_comb begin
    a_neg  = signed_i & a_i[DATA_W-1];
    b_neg  = signed_i & b_i[DATA_W-1];
    a_mag  = a_neg ? (~a_i + DATA_W'(1)) : a_i;
    b_mag  = b_neg ? (~b_i + DATA_W'(1)) : b_i;
    umul   = {{DATA_W{1'b0}}, a_mag} * {{DATA_W{1'b0}}, b_mag};
    prod_o = (a_neg ^ b_neg) ? (~umul + (2*DATA_W)'(1)) : umul;
  end

endmodule

// File: rtl/ex_madd_seq.sv
// EX-stage sequencer for MADD/MADDU/MSUB/MSUBU: HI:LO +/- rs*rt.
// Latency: 2 EX cycles (product, then accumulate); one bubble into EX/MEM.
// Requests a stall in the product cycle; holds the accumulate cycle while stall[3] is Stop.
module ex_madd_seq
  import ex_madd_seq_pkg::*;
#(
  parameter int DATA_W = MADD_DATA_W,
  parameter int OP_W   = MADD_OP_W
) (
  input  logic         clk,
  input  logic         rst,
  ex_madd_seq_if.slave bus
);

  madd_state_e         state_q;
  madd_state_e         state_d;
  logic [2*DATA_W-1:0] prod_q;
  logic [2*DATA_W-1:0] prod_d;
  logic [2*DATA_W-1:0] product;
  logic [2*DATA_W-1:0] hilo_cur;
  logic [OP_W-1:0]     aluop;
  logic                stall_ex;

  assign aluop    = bus.aluop_i;
  assign stall_ex = bus.stall[STALL_EX_BIT];
  assign hilo_cur = {bus.hi_i, bus.lo_i};

  ex_madd_seq_mul_core #(
    .DATA_W (DATA_W)
  ) u_mul_core (
    .signed_i (is_signed_op(aluop)),
    .a_i      (bus.reg1_i),
    .b_i      (bus.reg2_i),
    .prod_o   (product)
  );

  // Next-state and outputs; everything is forced to 0 while rst is asserted so HI/LO never
  // sees a partial write. Add/sub is taken from the live aluop in ACC, not a latched copy.
  always_comb begin
    state_d        = state_q;
    prod_d         = prod_q;
    bus.hilo_o     = '0;
    bus.whilo_o    = 1'b0;
    bus.stallreq_o = 1'b0;
    bus.busy_o     = 1'b0;
    if (rst == RST_ENABLE) begin
      state_d = MADD_IDLE;
      prod_d  = '0;
    end else begin
      case (state_q)
        MADD_IDLE: begin
          if (is_madd_op(aluop)) begin
            bus.stallreq_o = 1'b1;
            prod_d         = product;
            state_d        = MADD_ACC;
          end
        end
        MADD_ACC: begin
          bus.busy_o = 1'b1;
          if (is_madd_op(aluop)) begin
            bus.whilo_o = 1'b1;
            bus.hilo_o  = is_sub_op(aluop) ? (hilo_cur - prod_q) : (hilo_cur + prod_q);
            if (stall_ex == NO_STOP) begin
              state_d = MADD_IDLE;
            end
          end else begin
            // Non-madd op seen in ACC: abandon without writing HI/LO.
            state_d = MADD_IDLE;
          end
        end
        default: state_d = MADD_IDLE;
      endcase
    end
  end

  // State and product registers; product only changes on the IDLE->ACC edge.
  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      state_q <= MADD_IDLE;
      prod_q  <= '0;
    end else begin
      state_q <= state_d;
      prod_q  <= prod_d;
    end
  end

endmodule

// File: tb/tb_ex_madd_seq.sv
// Directed + random bench for ex_madd_seq: scoreboard queue of expected HI:LO values.
// Inputs are driven 1 time unit after the rising edge; outputs are checked 2 units later.
// Stall, reset-in-ACC and back-to-back sequences are covered explicitly.
module tb_ex_madd_seq;
  import ex_madd_seq_pkg::*;

  logic clk;
  logic rst;
  int   total;
  int   passed;
  logic [63:0] exp_q[$];

  ex_madd_seq_if bus();

  ex_madd_seq dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, total=%0d passed=%0d", total, passed);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed=0x%016h expected=0x%016h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Independent reference: sign-extend to 64 bits and multiply directly.
  function automatic logic [63:0] model(input logic [7:0] op, input logic [31:0] hi,
                                        input logic [31:0] lo, input logic [31:0] rs,
                                        input logic [31:0] rt);
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] p;
    if (op == EXE_MADD_OP || op == EXE_MSUB_OP) begin
      a = {{32{rs[31]}}, rs};
      b = {{32{rt[31]}}, rt};
    end else begin
      a = {32'h0, rs};
      b = {32'h0, rt};
    end
    p = a * b;
    if (op == EXE_MSUB_OP || op == EXE_MSUBU_OP) return {hi, lo} - p;
    return {hi, lo} + p;
  endfunction

  task automatic drive(input logic [7:0] op, input logic [31:0] hi, input logic [31:0] lo,
                       input logic [31:0] rs, input logic [31:0] rt);
    bus.aluop_i = op;
    bus.hi_i    = hi;
    bus.lo_i    = lo;
    bus.reg1_i  = rs;
    bus.reg2_i  = rt;
  endtask

  // Full two-cycle instruction; expected result pushed at issue, popped in ACC.
  task automatic run_madd(input string tag, input logic [7:0] op, input logic [31:0] hi,
                          input logic [31:0] lo, input logic [31:0] rs, input logic [31:0] rt,
                          input logic [63:0] exp);
    logic [63:0] e;
    drive(op, hi, lo, rs, rt);
    exp_q.push_back(exp);
    #2;
    chk({tag, ".c1.stallreq"}, 64'(bus.stallreq_o), 64'd1);
    chk({tag, ".c1.whilo"},    64'(bus.whilo_o),    64'd0);
    tick();
    #2;
    e = exp_q.pop_front();
    chk({tag, ".c2.hilo"},     bus.hilo_o,          e);
    chk({tag, ".c2.whilo"},    64'(bus.whilo_o),    64'd1);
    chk({tag, ".c2.stallreq"}, 64'(bus.stallreq_o), 64'd0);
    chk({tag, ".c2.busy"},     64'(bus.busy_o),     64'd1);
    tick();
    bus.aluop_i = 8'h00;
    #2;
    chk({tag, ".idle.busy"},   64'(bus.busy_o),     64'd0);
  endtask

  initial begin
    logic [63:0] e;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [7:0]  op;
    logic [7:0]  ops [4];
    total  = 0;
    passed = 0;
    ops[0] = EXE_MADD_OP;
    ops[1] = EXE_MADDU_OP;
    ops[2] = EXE_MSUB_OP;
    ops[3] = EXE_MSUBU_OP;

    rst       = 1'b1;
    bus.stall = 6'b0;
    drive(EXE_MADD_OP, 32'h1, 32'h2, 32'h3, 32'h4);
    tick();
    #2;
    chk("rst.hilo",     bus.hilo_o,              64'd0);
    chk("rst.whilo",    64'(bus.whilo_o),        64'd0);
    chk("rst.stallreq", 64'(bus.stallreq_o),     64'd0);
    chk("rst.busy",     64'(bus.busy_o),         64'd0);
    tick();
    rst = 1'b0;
    bus.aluop_i = 8'h00;
    #2;
    chk("nop.stallreq", 64'(bus.stallreq_o),     64'd0);
    chk("nop.busy",     64'(bus.busy_o),         64'd0);
    tick();

    run_madd("t1_madd",  EXE_MADD_OP,  32'h0, 32'h10, 32'h3, 32'h5, 64'h00000000_0000001F);
    run_madd("t2_msub",  EXE_MSUB_OP,  32'h0, 32'h0, 32'hFFFFFFFF, 32'h2, 64'h00000000_00000002);
    run_madd("t3_maddu", EXE_MADDU_OP, 32'h0, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFF,
             64'hFFFFFFFE_00000001);
    run_madd("t4_wrap",  EXE_MADDU_OP, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h1, 32'h1, 64'h0);
    run_madd("t_minmin", EXE_MADD_OP,  32'h0, 32'h0, 32'h80000000, 32'h80000000,
             64'h40000000_00000000);
    run_madd("t_msubu",  EXE_MSUBU_OP, 32'h0, 32'h0, 32'h1, 32'h1, 64'hFFFFFFFF_FFFFFFFF);

    for (int i = 0; i < 8; i++) begin
      op = ops[i % 4];
      rs = $urandom;
      rt = $urandom;
      hi = $urandom;
      lo = $urandom;
      run_madd("rand", op, hi, lo, rs, rt, model(op, hi, lo, rs, rt));
    end

    // Stall held from elsewhere while in ACC; operand changes must not disturb prod_q.
    drive(EXE_MADD_OP, 32'h0, 32'h0, 32'h7, 32'hFFFFFFFD);
    exp_q.push_back(64'hFFFFFFFF_FFFFFFEB);
    #2;
    chk("t5.c1.stallreq", 64'(bus.stallreq_o), 64'd1);
    tick();
    bus.stall = 6'b001111;
    #2;
    e = exp_q.pop_front();
    for (int i = 0; i < 3; i++) begin
      chk("t5.hold.hilo",     bus.hilo_o,          e);
      chk("t5.hold.whilo",    64'(bus.whilo_o),    64'd1);
      chk("t5.hold.stallreq", 64'(bus.stallreq_o), 64'd0);
      chk("t5.hold.busy",     64'(bus.busy_o),     64'd1);
      tick();
      bus.reg1_i = $urandom;
      bus.reg2_i = $urandom;
      if (i == 2) bus.stall = 6'b0;
      #2;
    end
    chk("t5.release.busy", 64'(bus.busy_o), 64'd1);
    chk("t5.release.hilo", bus.hilo_o,      e);
    tick();
    bus.aluop_i = 8'h00;
    #2;
    chk("t5.idle.busy",    64'(bus.busy_o), 64'd0);
    tick();

    // Non-madd op showing up in ACC: no HI/LO write, back to IDLE.
    drive(EXE_MADDU_OP, 32'h0, 32'h0, 32'h2, 32'h2);
    tick();
    bus.aluop_i = 8'h21;
    #2;
    chk("def.whilo", 64'(bus.whilo_o), 64'd0);
    chk("def.busy",  64'(bus.busy_o),  64'd1);
    tick();
    #2;
    chk("def.idle.busy", 64'(bus.busy_o), 64'd0);
    tick();

    // Reset landing in ACC, then back-to-back MADDs.
    drive(EXE_MADD_OP, 32'h0, 32'h0, 32'h2, 32'h3);
    #2;
    chk("t6.c1.stallreq", 64'(bus.stallreq_o), 64'd1);
    tick();
    rst = 1'b1;
    #2;
    chk("t6.rst.hilo",     bus.hilo_o,          64'd0);
    chk("t6.rst.whilo",    64'(bus.whilo_o),    64'd0);
    chk("t6.rst.stallreq", 64'(bus.stallreq_o), 64'd0);
    chk("t6.rst.busy",     64'(bus.busy_o),     64'd0);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #2;
      if (i % 2 == 0) begin
        exp_q.push_back(64'd6);
        chk("t6.b2b.stallreq", 64'(bus.stallreq_o), 64'd1);
        chk("t6.b2b.busy",     64'(bus.busy_o),     64'd0);
      end else begin
        e = exp_q.pop_front();
        chk("t6.b2b.stallreq", 64'(bus.stallreq_o), 64'd0);
        chk("t6.b2b.whilo",    64'(bus.whilo_o),    64'd1);
        chk("t6.b2b.hilo",     bus.hilo_o,          e);
      end
      tick();
    end
    bus.aluop_i = 8'h00;
    #2;
    chk("t6.end.busy", 64'(bus.busy_o), 64'd0);
    chk("sb.empty", 64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
